// File: rtl/mux_pkg.sv
// Shared helpers for the binary-select mux tree family.
// Level count and WIDTH/SPLIT legality are computed here.
package mux_pkg;

    function automatic int mux_levels(input int width, input int split);
        return $clog2(width) / $clog2(split);
    endfunction

    function automatic bit mux_legal(input int width, input int split);
        int w;
        if (split < 2 || (split & (split - 1)) != 0) return 1'b0;
        w = width;
        for (int i = 0; i < 32; i++) begin
            if (w > 1 && (w % split) == 0) w = w / split;
        end
        return (width >= split) && (w == 1);
    endfunction

endpackage

// File: rtl/mux_bin_base.sv
// Combinational binary-select mux: dat = ary[bin].
// IMPLEMENTATION picks an indexed read or a compare chain.
module mux_bin_base #(
    parameter type DAT_T          = logic [8-1:0],
    parameter int  WIDTH          = 2,
    parameter int  IMPLEMENTATION = 0,
    localparam int BW             = $clog2(WIDTH)
) (
    input  logic [BW-1:0]    bin,
    input  DAT_T [WIDTH-1:0] ary,
    output DAT_T             dat
);

    if (IMPLEMENTATION == 0) begin : g_idx
        assign dat = ary[bin];
    end else begin : g_cmp
        always_comb begin
            dat = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (bin == BW'(i)) dat = ary[i];
            end
        end
    end

endmodule

// File: rtl/mux_bin_pipe_stage.sv
// One tree level: WIDTH_IN/SPLIT radix-SPLIT muxes feeding a
// valid/select/data register with collapsing-bubble load control.
module mux_bin_pipe_stage #(
    parameter type DAT_T          = logic [8-1:0],
    parameter int  WIDTH_IN       = 2,
    parameter int  SPLIT          = 2,
    parameter int  SEL_W          = 1,
    parameter int  IMPLEMENTATION = 0,
    localparam int SPLIT_LOG      = $clog2(SPLIT),
    localparam int WIDTH_OUT      = WIDTH_IN / SPLIT,
    localparam int SEL_OW         = (SEL_W > SPLIT_LOG) ? SEL_W - SPLIT_LOG : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    input  logic [SEL_W-1:0]     in_sel,
    input  DAT_T [WIDTH_IN-1:0]  in_ary,
    input  logic                 dn_acc,
    output logic                 load,
    output logic                 out_vld,
    output logic [SEL_OW-1:0]    out_sel,
    output DAT_T [WIDTH_OUT-1:0] out_dat
);

    DAT_T [WIDTH_OUT-1:0] mux_d;

    for (genvar g = 0; g < WIDTH_OUT; g++) begin : g_mux
        mux_bin_base #(
            .DAT_T         (DAT_T),
            .WIDTH         (SPLIT),
            .IMPLEMENTATION(IMPLEMENTATION)
        ) u_mux (
            .bin(in_sel[SPLIT_LOG-1:0]),
            .ary(in_ary[g*SPLIT +: SPLIT]),
            .dat(mux_d[g])
        );
    end

    // An empty stage always loads, so bubbles collapse under a stall.
    assign load = !out_vld || dn_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
        end else if (load) begin
            out_vld <= in_vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_dat <= '0;
        end else if (load && in_vld) begin
            out_dat <= mux_d;
        end
    end

    if (SEL_W > SPLIT_LOG) begin : g_sel
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_sel <= '0;
            end else if (load && in_vld) begin
                out_sel <= in_sel[SEL_W-1:SPLIT_LOG];
            end
        end
    end else begin : g_nosel
        assign out_sel = '0;
    end

endmodule

// File: rtl/mux_bin_pipe.sv
// Pipelined radix-SPLIT mux tree selecting ary[bin], one
// register stage per level, valid/ready on both sides.
module mux_bin_pipe
    import mux_pkg::*;
#(
    parameter type DAT_T          = logic [8-1:0],
    parameter int  WIDTH          = 32,
    parameter int  SPLIT          = 2,
    parameter int  IMPLEMENTATION = 0,
    localparam int WIDTH_LOG      = $clog2(WIDTH),
    localparam int SPLIT_LOG      = $clog2(SPLIT),
    localparam int LEVELS         = mux_levels(WIDTH, SPLIT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_vld,
    output logic                 i_rdy,
    input  logic [WIDTH_LOG-1:0] bin,
    input  DAT_T [WIDTH-1:0]     ary,
    output logic                 o_vld,
    input  logic                 o_rdy,
    output DAT_T                 dat
);

    if (!mux_legal(WIDTH, SPLIT)) begin : g_illegal
        $error("mux_bin_pipe: WIDTH must be a power of SPLIT >= 2");
    end

    logic sel_unused;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int WI = WIDTH / (SPLIT ** k);
        localparam int WO = WI / SPLIT;
        localparam int SI = WIDTH_LOG - k * SPLIT_LOG;
        localparam int SO = (SI > SPLIT_LOG) ? SI - SPLIT_LOG : 1;

        DAT_T [WI-1:0] di;
        logic [SI-1:0] si;
        logic          vi;
        logic          acc;
        logic          ld;
        logic          v;
        logic [SO-1:0] s;
        DAT_T [WO-1:0] d;

        if (k == 0) begin : g_head
            assign di = ary;
            assign si = bin;
            assign vi = i_vld;
        end else begin : g_body
            assign di = g_lvl[k-1].d;
            assign si = g_lvl[k-1].s;
            assign vi = g_lvl[k-1].v;
        end

        if (k == LEVELS - 1) begin : g_tail
            assign acc = o_rdy;
        end else begin : g_mid
            assign acc = g_lvl[k+1].ld;
        end

        mux_bin_pipe_stage #(
            .DAT_T         (DAT_T),
            .WIDTH_IN      (WI),
            .SPLIT         (SPLIT),
            .SEL_W         (SI),
            .IMPLEMENTATION(IMPLEMENTATION)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .in_vld (vi),
            .in_sel (si),
            .in_ary (di),
            .dn_acc (acc),
            .load   (ld),
            .out_vld(v),
            .out_sel(s),
            .out_dat(d)
        );
    end

    assign i_rdy      = g_lvl[0].ld;
    assign o_vld      = g_lvl[LEVELS-1].v;
    assign dat        = g_lvl[LEVELS-1].d[0];
    assign sel_unused = ^g_lvl[LEVELS-1].s;

endmodule

// File: doc/mux_bin_pipe.md
MUX_BIN_PIPE -- requirements
Module: mux_bin_pipe

Interface
REQ-001 SHALL have parameter DAT_T, default logic [8-1:0], the data element type.
REQ-002 SHALL have parameter WIDTH, default 32, the number of array elements; WIDTH SHALL be a power of SPLIT.
REQ-003 SHALL have parameter SPLIT, default 2, the tree radix per level; SPLIT SHALL be a power of 2 and at least 2.
REQ-004 SHALL have parameter IMPLEMENTATION, default 0, passed unchanged to every mux_bin_base instance.
REQ-005 SHALL have localparams WIDTH_LOG=$clog2(WIDTH), SPLIT_LOG=$clog2(SPLIT) and LEVELS=WIDTH_LOG/SPLIT_LOG.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-008 SHALL have port i_vld, input, 1 bit, input transfer valid.
REQ-009 SHALL have port i_rdy, output, 1 bit, input transfer ready.
REQ-010 SHALL have port bin, input, WIDTH_LOG bits, the binary select, qualified by i_vld.
REQ-011 SHALL have port ary, input, DAT_T [WIDTH-1:0], the data array, qualified by i_vld.
REQ-012 SHALL have port o_vld, output, 1 bit, output transfer valid.
REQ-013 SHALL have port o_rdy, input, 1 bit, output transfer ready.
REQ-014 SHALL have port dat, output, DAT_T, the selected element ary[bin] of the accepted transfer.

Function
REQ-015 A transfer SHALL occur on any port when vld and rdy are both high at a rising clk edge.
REQ-016 The datapath SHALL be a radix-SPLIT tree with LEVELS levels; level 1 (leaves) SHALL reduce groups of SPLIT adjacent elements using bin[SPLIT_LOG-1:0].
REQ-017 Level k SHALL use select slice bin[k*SPLIT_LOG-1 -: SPLIT_LOG]; the top level SHALL use the MSB slice.
REQ-018 Each level SHALL end in a register stage holding: that level's results, the unconsumed upper select bits, and one valid bit.
REQ-019 Latency from input transfer to o_vld SHALL be exactly LEVELS cycles with no stalls; for WIDTH=SPLIT it SHALL be 1 cycle.
REQ-020 Throughput SHALL be one transfer per cycle while o_rdy is held high.
REQ-021 Stage k SHALL load when its valid bit is low or stage k+1 accepts; the last stage's downstream accept SHALL be o_rdy.
REQ-022 i_rdy SHALL equal the stage-1 load condition; it SHALL be combinational from o_rdy and the stage valid bits only.
REQ-023 While o_vld=1 and o_rdy=0, dat and o_vld SHALL hold stable until the transfer completes.
REQ-024 Pipeline bubbles SHALL collapse: an empty stage SHALL accept new data even while downstream is stalled.
REQ-025 Transfers SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-026 bin and ary SHALL be ignored when i_vld=0; an empty stage's data registers MAY hold stale values.
REQ-027 All bin values 0..WIDTH-1 SHALL be legal; there is no out-of-range case.

Reset
REQ-028 While rst_n=0, all stage valid bits and o_vld SHALL be 0 and dat SHALL be '0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight transfers, with no output transfer for them after release.
REQ-030 i_rdy SHALL be 1 from the first clk edge after rst_n deasserts.

Structure
REQ-031 A shared package mux_pkg SHALL provide the function computing LEVELS from WIDTH and SPLIT, plus a legality check (WIDTH a power of SPLIT).
REQ-032 An elaboration-time assertion SHALL fail the build on illegal WIDTH/SPLIT.
REQ-033 One sub-module, mux_bin_pipe_stage, SHALL implement one level: WIDTH_IN/SPLIT existing mux_bin_base instances, plus the valid/select/data registers and load logic.
REQ-034 mux_bin_pipe SHALL be a generate loop of LEVELS mux_bin_pipe_stage instances.

Verification
REQ-035 Basic select: WIDTH=8, SPLIT=2, ary[i]=8'h10+i, bin=5, o_rdy=1 -> dat=8'h15 with o_vld=1 exactly 3 cycles after acceptance.
REQ-036 Streaming: 8 back-to-back transfers, bin=0..7, o_rdy=1 -> outputs 8'h10..8'h17 on 8 consecutive cycles, i_rdy constantly 1.
REQ-037 Backpressure: o_rdy=0 for 5 cycles while i_vld=1 -> i_rdy drops once all 3 stages are full, dat stays stable, no loss or reorder after o_rdy=1.
REQ-038 Reset mid-flight: rst_n=0 while 2 transfers are in flight -> o_vld=0 and dat=0 immediately, neither transfer emerges after release.
REQ-039 Degenerate/wide radix: WIDTH=SPLIT=4 with bin=3 -> ary[3] at latency 1; WIDTH=64, SPLIT=4 with bin=6'h2A -> ary[42] at latency 3.
REQ-040 Randomised o_rdy and i_vld for 10k cycles against a scoreboard -> every output equals ary[bin] in acceptance order.
